dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory between the MIPS core (requester 0) and a secondary master such as a loader or debug DMA (requester 1). It sits between the requesters and the data memory's we/addr/wdata/rdata interface, and grants at most one access per cycle. The core has fixed priority, and a starvation counter guarantees requester 1 forward progress. Read data is registered and returned with a one-cycle rvalid pulse.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive cycles requester 1 may wait before it is forced ahead of requester 0; legal range 0..15; 0 means requester 1 always wins

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  core access request; held until granted
m0_we  in  1  core write enable (1 = write, 0 = read)
m0_addr  in  AW  core byte address
m0_wdata  in  DW  core write data
m0_gnt  out  1  core granted this cycle; the core stalls while req=1 and gnt=0
m0_rdata  out  DW  registered read data for the core
m0_rvalid  out  1  m0_rdata valid (one-cycle pulse)
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same widths and meanings for requester 1
mem_we  out  1  to data memory we
mem_addr  out  AW  to data memory addr
mem_wdata  out  DW  to data memory wdata
mem_rdata  in  DW  from data memory; combinational read of mem_addr

Behaviour:
- Grant logic is combinational from the reqs and the starvation counter. Grants are one-hot or zero. Both gnts are forced to 0 while reset=1.
- Normal priority:
  - m0_req=1 gives m0_gnt=1.
  - Otherwise m1_req=1 gives m1_gnt=1.
- Forced grant: if m1_req=1 and starve_cnt >= STARVE_LIMIT, then m1_gnt=1 and m0_gnt=0 that cycle.
- Memory mux:
  - mem_addr/mem_wdata come from the granted requester; requester 0 is selected when none is granted.
  - mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we).
  - mem_we is 0 when nothing is granted and during reset.
- An access completes in its grant cycle. The write commits at that rising edge.
- Read return:
  - On a granted read, mem_rdata is captured into the requester's rdata register at the edge.
  - The requester's rvalid is 1 in the following cycle only.
  - A write grant produces no rvalid.
  - Back-to-back granted reads keep rvalid high on consecutive cycles with fresh data.
- rdata registers hold their value until the next read for that requester.
- Starvation counter (width 4):
  - Increments when m1_req=1 and m1_gnt=0, saturating at 15.
  - Clears to 0 on m1_gnt=1 or m1_req=0.
  - After a forced m1 grant the counter is 0, so m0 wins the next contested cycle.
- Worst-case waits:
  - Requester 1: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1 of its request.
  - Requester 0: 1 cycle.
- Request protocol: a requester must hold req/we/addr/wdata stable until gnt. Dropping req before grant is legal and clears the counter for requester 1.
- Reset (synchronous, mid-operation included):
  - starve_cnt=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0.
  - A read granted in the cycle reset asserts is discarded: no rvalid after reset.
- Simultaneous events:
  - Both requesting writes: only the winner writes; the loser holds.
  - Both requesters using the same address in consecutive cycles: sequential consistency follows grant order.

Decomposition:
- Package dmem_arb_pkg holds:
  - requester index constants REQ_CORE=0, REQ_AUX=1;
  - default AW/DW;
  - starvation counter width constant STARVE_W=4.
- One sub-module, dmem_arb_starve_ctr: the saturating counter plus the force-flag compare (inputs clk, reset, req, gnt, limit; output force).
- Mux, grant and rdata registers stay in dmem_arbiter.

Test Plan:
- Core-only read, addr 0x10 holding 0xDEADBEEF → m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1 outputs idle.
- Aux-only write 0x20←0x12345678, then core read 0x20 → mem_we=1 for exactly one cycle; core later reads 0x12345678.
- Both requesting continuously, STARVE_LIMIT=4 → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1…; m1 granted in its 5th cycle of request; gnts never both high.
- Aux request withdrawn after 3 waiting cycles, then reasserted → counter restarts; m1 forced only after 4 further waiting cycles.
- Reset asserted in the cycle of a granted core read → no m0_rvalid afterwards; all rvalid/rdata 0; mem_we=0 while reset=1.
- STARVE_LIMIT=0 with both requesting → m1 granted every cycle; m0_gnt stays 0 until m1_req drops.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: requester indices,
// default bus widths and the starvation counter width.
package dmem_arb_pkg;

  localparam int REQ_CORE = 0;
  localparam int REQ_AUX  = 1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'hF;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating wait counter for the auxiliary requester. It counts cycles the
// requester has been refused and raises force_grant once that wait reaches
// the configured limit, so the aux master cannot be starved by the core.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                gnt,
  input  logic [STARVE_W-1:0] limit,
  output logic                force_grant
);

  logic [STARVE_W-1:0] cnt_r;

  // Count refused cycles; any grant or withdrawn request restarts the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (!req || gnt) begin
      cnt_r <= 4'd0;
    end else if (cnt_r != STARVE_MAX) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A limit of zero makes the compare always true, so aux always wins.
  assign force_grant = req & (cnt_r >= limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory. The core
// (requester 0) has fixed priority; the aux master (requester 1) is pushed
// ahead after waiting STARVE_LIMIT cycles. Read data is registered per
// requester and flagged with a one-cycle rvalid pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [1:0] gnt_s;
  logic       force_s;
  logic       rd0_s;
  logic       rd1_s;

  dmem_arb_starve_ctr u_starve (
    .clk         (clk),
    .reset       (reset),
    .req         (m1_req),
    .gnt         (gnt_s[REQ_AUX]),
    .limit       (LIMIT),
    .force_grant (force_s)
  );

  // Grant selection: starving aux first, then the core, then idle aux.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else if (m1_req && force_s) begin
      gnt_s[REQ_AUX] = 1'b1;
    end else if (m0_req) begin
      gnt_s[REQ_CORE] = 1'b1;
    end else if (m1_req) begin
      gnt_s[REQ_AUX] = 1'b1;
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign m0_gnt = gnt_s[REQ_CORE];
  assign m1_gnt = gnt_s[REQ_AUX];

  // Memory-side mux; the core's bus is presented whenever aux is not granted.
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  assign mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we);

  assign rd0_s = m0_gnt & ~m0_we;
  assign rd1_s = m1_gnt & ~m1_we;

  // Capture read data for whichever requester read this cycle and pulse rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= rd0_s;
      m1_rvalid <= rd1_s;
      if (rd0_s) begin
        m0_rdata <= mem_rdata;
      end else begin
        m0_rdata <= m0_rdata;
      end
      if (rd1_s) begin
        m1_rdata <= mem_rdata;
      end else begin
        m1_rdata <= m1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Stimulus pushes expected read data into
// per-requester queues; a negedge monitor pops and compares on each rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Second instance with STARVE_LIMIT=0
  logic        b_m0_req, b_m1_req;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_a0 = 32'h0000_0040;
  logic [31:0] b_a1 = 32'h0000_0044;
  logic [31:0] b_d  = 32'h0000_0000;
  logic [31:0] b_rd = 32'hA5A5_5A5A;
  logic        b_we = 1'b1;

  logic [31:0] mem [0:63];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_we), .m0_addr(b_a0), .m0_wdata(b_d),
    .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
    .m1_req(b_m1_req), .m1_we(b_we), .m1_addr(b_a1), .m1_wdata(b_d),
    .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_rd)
  );

  // Word-addressed memory model: combinational read, write at the edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (m0_rvalid === 1'b1) begin
        if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'd1, 32'd0);
        else chk("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid === 1'b1) begin
        if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'd1, 32'd0);
        else chk("m1_rdata", m1_rdata, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEAD_BEEF;
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    cyc(); cyc();
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);

    // Core-only read of 0x10
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #1;
    chk("t1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("t1_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h10);
    q0.push_back(32'hDEAD_BEEF);
    cyc();
    m0_req = 1'b0;
    #1;
    chk("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("t1_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    cyc();

    // Aux-only write 0x20 <- 0x12345678, then core reads it back
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    #1;
    chk("t2_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h20);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    m1_req = 1'b0;
    #1;
    chk("t2_mem_we_off", {31'd0, mem_we}, 32'd0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    #1;
    chk("t2_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    q0.push_back(32'h1234_5678);
    cyc();
    m0_req = 1'b0;
    cyc(); cyc();

    // Both reading continuously: m1 forced every 5th cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_m1_gnt_%0d", i), {31'd0, m1_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_m0_gnt_%0d", i), {31'd0, m0_gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
      if (i % 5 == 4) q1.push_back(32'h1234_5678);
      else q0.push_back(32'hDEAD_BEEF);
      cyc();
    end
    m1_req = 1'b0;

    // Aux waits 3 cycles, withdraws, then must wait 4 fresh cycles
    for (int i = 0; i < 3; i++) begin
      m1_req = 1'b1;
      #1;
      chk($sformatf("t4a_m1_gnt_%0d", i), {31'd0, m1_gnt}, 32'd0);
      q0.push_back(32'hDEAD_BEEF);
      cyc();
    end
    m1_req = 1'b0;
    q0.push_back(32'hDEAD_BEEF);
    cyc();
    m1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4b_m1_gnt_%0d", i), {31'd0, m1_gnt}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) q1.push_back(32'h1234_5678);
      else q0.push_back(32'hDEAD_BEEF);
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(); cyc();

    // Reset in the cycle of a core read plus an aux write
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hBAD0_BAD0;
    #1;
    chk("t5_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("t5_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("t5_mem_we", {31'd0, mem_we}, 32'd0);
    cyc();
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk("t5_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("t5_m0_rdata", m0_rdata, 32'd0);
    chk("t5_m1_rdata", m1_rdata, 32'd0);
    cyc();
    chk("t5_m0_rvalid_late", {31'd0, m0_rvalid}, 32'd0);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    q1.push_back(32'h1234_5678);
    cyc();
    m1_req = 1'b0;
    cyc(); cyc();

    // STARVE_LIMIT=0: aux wins every contested cycle
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t6_b_m1_gnt_%0d", i), {31'd0, b_m1_gnt}, 32'd1);
      chk($sformatf("t6_b_m0_gnt_%0d", i), {31'd0, b_m0_gnt}, 32'd0);
      cyc();
    end
    b_m1_req = 1'b0;
    #1;
    chk("t6_b_m0_gnt_free", {31'd0, b_m0_gnt}, 32'd1);
    chk("t6_b_m1_gnt_free", {31'd0, b_m1_gnt}, 32'd0);
    cyc();
    b_m0_req = 1'b0;
    cyc(); cyc();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Grants must never both be high on either instance.
  always @(negedge clk) begin
    if ((m0_gnt & m1_gnt) === 1'b1) chk("onehot_gnt", 32'd1, 32'd0);
    if ((b_m0_gnt & b_m1_gnt) === 1'b1) chk("onehot_b_gnt", 32'd1, 32'd0);
  end

endmodule
